half_sub_1bit: RTL and testbench

//  1-bit half subtractor computing a - b: difference d and borrow-out bout.

---
 rtl/half_sub_1bit.sv | 100 ++++++++++
 tb/tb_half_sub_1bit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/half_sub_1bit.sv
// -----------------------------------------------------------------------------
// half_sub_1bit
//   1-bit half subtractor computing a - b, the leaf cell of the ALU subtract
//   path. The difference/borrow pair is either registered with an
//   in_valid/out_valid qualifier (REG_OUT=1, one cycle of latency) or passed
//   straight through combinationally (REG_OUT=0). A saturating counter of
//   accepted operations that borrowed gives the ALU some debug visibility.
//
// Parameters
//   REG_OUT     1: d/bout/out_valid registered; 0: combinational d/bout
//   CNT_W       width of borrow_cnt
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous active-low reset
//   a           in   1      minuend bit
//   b           in   1      subtrahend bit
//   in_valid    in   1      a/b qualify this cycle
//   cnt_clr     in   1      synchronous clear of borrow_cnt (beats increment)
//   d           out  1      difference, a ^ b
//   bout        out  1      borrow out, ~a & b
//   out_valid   out  1      d/bout qualify this cycle
//   borrow_cnt  out  CNT_W  accepted operations that produced a borrow
// -----------------------------------------------------------------------------
module half_sub_1bit #(
   parameter bit REG_OUT = 1'b1,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             in_valid,
   input  logic             cnt_clr,
   output logic             d,
   output logic             bout,
   output logic             out_valid,
   output logic [CNT_W-1:0] borrow_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic diff_q;    // qualified difference
   logic borrow_q;  // qualified borrow

   // Operands are only looked at when in_valid is high, so X/Z on an idle
   // bus can never leak into the outputs or the counter.
   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      diff_q   = 1'b0;
      borrow_q = 1'b0;
      if (in_valid) begin
         diff_q   = a ^ b;
         borrow_q = ~a & b;
      end
   end

   // Borrow-event counter: clear wins over increment, and it sticks at the
   // all-ones value instead of wrapping.
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         borrow_cnt <= '0;
      end else if (cnt_clr) begin
         borrow_cnt <= '0;
      end else if (borrow_q && (borrow_cnt != CNT_MAX)) begin
         borrow_cnt <= borrow_cnt + CNT_ONE;
      end
   end

   generate
      if (REG_OUT) begin : g_reg
         // d/bout hold their last accepted result across idle cycles;
         // only out_valid drops.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               d         <= 1'b0;
               bout      <= 1'b0;
               out_valid <= 1'b0;
            end else begin
               out_valid <= in_valid;
               if (in_valid) begin
                  d    <= diff_q;
                  bout <= borrow_q;
               end
            end
         end
      end else begin : g_comb
         always_comb begin
            d         = diff_q;
            bout      = borrow_q;
            out_valid = in_valid;
         end
      end
   endgenerate

endmodule

// File: tb/tb_half_sub_1bit.sv
// -----------------------------------------------------------------------------
// tb_half_sub_1bit
//   Three instances share one stimulus stream: registered with an 8-bit
//   counter, registered with a 2-bit counter (saturation), and combinational.
//   A behavioural model treats each operation as an integer subtraction a - b
//   (difference = low bit, borrow = result below zero) and is compared with
//   every instance on each falling edge; directed checks with literal values
//   pin the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_half_sub_1bit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       a = 1'b0;
   logic       b = 1'b0;
   logic       in_valid = 1'b0;
   logic       cnt_clr = 1'b0;

   logic       d_r, bout_r, ov_r;
   logic [7:0] cnt_r;
   logic       d_s, bout_s, ov_s;
   logic [1:0] cnt_s;
   logic       d_c, bout_c, ov_c;
   logic [7:0] cnt_c;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   always #10 clk = ~clk;

   half_sub_1bit #(.REG_OUT(1'b1), .CNT_W(8)) u_reg (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .d(d_r), .bout(bout_r), .out_valid(ov_r),
      .borrow_cnt(cnt_r));

   half_sub_1bit #(.REG_OUT(1'b1), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .d(d_s), .bout(bout_s), .out_valid(ov_s),
      .borrow_cnt(cnt_s));

   half_sub_1bit #(.REG_OUT(1'b0), .CNT_W(8)) u_comb (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
      .cnt_clr(cnt_clr), .d(d_c), .bout(bout_c), .out_valid(ov_c),
      .borrow_cnt(cnt_c));

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int sub_int(input logic x, input logic y);
      return int'(x) - int'(y);
   endfunction

   function automatic int sat_inc(input int v, input int max);
      return (v + 1 > max) ? max : v + 1;
   endfunction

   int m_d = 0, m_b = 0, m_v = 0, m_cnt8 = 0, m_cnt2 = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_d = 0; m_b = 0; m_v = 0; m_cnt8 = 0; m_cnt2 = 0;
      end else begin
         int r;
         r   = 0;
         m_v = (in_valid === 1'b1) ? 1 : 0;
         if (in_valid === 1'b1) begin
            r   = sub_int(a, b);
            m_d = r & 1;
            m_b = (r < 0) ? 1 : 0;
         end
         if (cnt_clr === 1'b1) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
         end else if (in_valid === 1'b1 && r < 0) begin
            m_cnt8 = sat_inc(m_cnt8, 255);
            m_cnt2 = sat_inc(m_cnt2, 3);
         end
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         int cd, cb;
         cd = 0;
         cb = 0;
         if (in_valid === 1'b1) begin
            cd = sub_int(a, b) & 1;
            cb = (sub_int(a, b) < 0) ? 1 : 0;
         end
         check("reg.d",        d_r,    m_d);
         check("reg.bout",     bout_r, m_b);
         check("reg.ov",       ov_r,   m_v);
         check("reg.cnt",      cnt_r,  m_cnt8);
         check("sat.d",        d_s,    m_d);
         check("sat.bout",     bout_s, m_b);
         check("sat.ov",       ov_s,   m_v);
         check("sat.cnt",      cnt_s,  m_cnt2);
         check("comb.d",       d_c,    cd);
         check("comb.bout",    bout_c, cb);
         check("comb.ov",      ov_c,   in_valid);
         check("comb.cnt",     cnt_c,  m_cnt8);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input logic ia, input logic ib, input logic iv,
                       input logic ic);
      @(negedge clk);
      #2;
      a = ia; b = ib; in_valid = iv; cnt_clr = ic;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_reg(input string tag, input logic ed, input logic eb,
                             input logic ev, input int ec8, input int ec2);
      check({tag, ".d"},    d_r,    ed);
      check({tag, ".bout"}, bout_r, eb);
      check({tag, ".ov"},   ov_r,   ev);
      check({tag, ".cnt8"}, cnt_r,  ec8);
      check({tag, ".cnt2"}, cnt_s,  ec2);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #4 cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      expect_reg("post_reset", 1'b0, 1'b0, 1'b0, 0, 0);

      // Truth table, one vector per 20 ns cycle, result one edge later.
      step(1'b0, 1'b0, 1'b1, 1'b0); expect_reg("tt00", 1'b0, 1'b0, 1'b1, 0, 0);
      step(1'b0, 1'b1, 1'b1, 1'b0); expect_reg("tt01", 1'b1, 1'b1, 1'b1, 1, 1);
      step(1'b1, 1'b0, 1'b1, 1'b0); expect_reg("tt10", 1'b1, 1'b0, 1'b1, 1, 1);
      step(1'b1, 1'b1, 1'b1, 1'b0); expect_reg("tt11", 1'b0, 1'b0, 1'b1, 1, 1);

      // Idle with a=b=1 after a (0,1): result held, out_valid low.
      step(1'b0, 1'b1, 1'b1, 1'b0); expect_reg("pre_hold", 1'b1, 1'b1, 1'b1, 2, 2);
      step(1'b1, 1'b1, 1'b0, 1'b0); expect_reg("hold",     1'b1, 1'b1, 1'b0, 2, 2);
      step(1'bx, 1'bx, 1'b0, 1'b0); expect_reg("idle_x",   1'b1, 1'b1, 1'b0, 2, 2);
      check("idle_x.comb_d", d_c, 1'b0);

      // Counter: clear, three borrows, clear beating an increment.
      step(1'b0, 1'b0, 1'b1, 1'b1); expect_reg("clr", 1'b0, 1'b0, 1'b1, 0, 0);
      repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
      expect_reg("cnt3", 1'b1, 1'b1, 1'b1, 3, 3);
      step(1'b0, 1'b1, 1'b1, 1'b1); expect_reg("clr_prio", 1'b1, 1'b1, 1'b1, 0, 0);

      // Saturation of the 2-bit counter.
      repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0);
      expect_reg("sat5", 1'b1, 1'b1, 1'b1, 5, 3);
      step(1'b0, 1'b1, 1'b1, 1'b0); expect_reg("sat6", 1'b1, 1'b1, 1'b1, 6, 3);

      // Asynchronous reset mid-stream, away from any clock edge.
      @(negedge clk);
      #2 a = 1'b0; b = 1'b1; in_valid = 1'b1; cnt_clr = 1'b0;
      #3 rst_n = 1'b0;
      #1 expect_reg("async_rst", 1'b0, 1'b0, 1'b0, 0, 0);
      check("async_rst.comb_cnt", cnt_c, 0);
      @(posedge clk);
      #1 expect_reg("rst_hold", 1'b0, 1'b0, 1'b0, 0, 0);
      @(negedge clk);
      #2 rst_n = 1'b1; in_valid = 1'b0;
      step(1'b1, 1'b0, 1'b1, 1'b0); expect_reg("first_op", 1'b1, 1'b0, 1'b1, 0, 0);

      // Combinational build: result visible before any clock edge.
      @(negedge clk);
      #2 a = 1'b0; b = 1'b1; in_valid = 1'b1; cnt_clr = 1'b0;
      #1;
      check("comb01.d",    d_c,    1'b1);
      check("comb01.bout", bout_c, 1'b1);
      check("comb01.ov",   ov_c,   1'b1);
      @(posedge clk);
      #1 check("comb01.cnt", cnt_c, 1);

      step(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1 cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
